eh2_lsu_dccm_arb: RTL and testbench
===================================

# eh2_lsu_dccm_arb

Arbiter and sequencer for the banked DCCM array. Three requesters share the array's single read/write command interface: the load pipe, the DMA slave port, and the store-buffer drain. At most one command is issued per cycle. Read responses are returned to the correct requester with a fixed latency. The block sits between the LSU pipe/store buffer/DMA and the DCCM memory wrapper, and drives all of the wrapper's command inputs.

## Interface
Parameters:
- DCCM_BITS, 16: byte-address width into DCCM.
- DATA_W, 39: per-bank data width (32 data + 7 ECC).
- STARVE_MAX, 4: consecutive lost arbitration cycles before a requester is promoted; valid range 1..15.
- LOAD_TO_USE_PLUS1, 0: 1 adds one cycle of read latency, matching the memory wrapper's registered-output option.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ld_req_valid  in  1  load read request.
- ld_req_ready  out  1  load granted this cycle.
- ld_addr_lo, ld_addr_hi  in  DCCM_BITS  low/high bank addresses (equal when the access is aligned).
- dma_req_valid  in  1  DMA request.
- dma_req_ready  out  1  DMA granted.
- dma_req_write  in  1  1 = write, 0 = read.
- dma_addr  in  DCCM_BITS  DMA address (always aligned).
- dma_wdata  in  DATA_W  DMA write data.
- stb_req_valid  in  1  store-buffer drain request.
- stb_req_ready  out  1  store granted.
- stb_addr_lo, stb_addr_hi  in  DCCM_BITS  store addresses.
- stb_wdata_lo, stb_wdata_hi  in  DATA_W  store data.
- dccm_rden, dccm_wren  out  1  memory command.
- dccm_rd_addr_lo/hi, dccm_wr_addr_lo/hi  out  DCCM_BITS  memory addresses.
- dccm_wr_data_lo/hi  out  DATA_W  memory write data.
- dccm_rd_data_lo/hi  in  DATA_W  memory read data.
- ld_rsp_valid, dma_rsp_valid  out  1  read response strobes.
- rsp_data_lo, rsp_data_hi  out  DATA_W  response data (shared by both responders).

## Operation
- **Grant rule.** Exactly one grant, or none, per cycle. Grant is combinational from the same-cycle valids and ready equals grant. A requester must hold its valid and payload stable until ready is seen.
- **Base priority.** load > DMA > store.
- **Starvation counters.**
  - Each of DMA and store owns a saturating counter, width 4.
  - The counter increments when its valid is high and it is not granted.
  - The counter clears when the requester is granted or its valid is low.
  - A counter equal to STARVE_MAX promotes that requester above load.
  - If both counters are promoted, DMA wins. The store counter then keeps its value and the store wins on the following cycle unless a new promotion intervenes.
- **Load grant.** dccm_rden=1. dccm_rd_addr_lo/hi = ld_addr_lo/hi.
- **DMA read grant.** dccm_rden=1. Both read addresses = dma_addr.
- **DMA write grant.** dccm_wren=1. Both write addresses = dma_addr. Both write data = dma_wdata.
- **Store grant.** dccm_wren=1. Write addresses and write data come from the stb ports.
- **Idle.** When no request is granted, dccm_rden and dccm_wren are 0. Address and data outputs then hold their previous values; they are don't-care but must be X-free after reset.
- **Response tag pipeline.** A 2-bit tag pipeline, {is_ld, is_dma}, of depth 1 (or 2 when LOAD_TO_USE_PLUS1=1) records each granted read.
  - At the end of the pipeline the tag drives ld_rsp_valid or dma_rsp_valid.
  - rsp_data_lo/hi = dccm_rd_data_lo/hi, passed through combinationally.
- **No in-block hazard checking.** Read-after-write ordering is guaranteed because the memory is single-ported and commands are issued in grant order. A write and a read are never issued in the same cycle.

## Timing
- Reset values:
  - ld_req_ready, dma_req_ready, stb_req_ready = 0 while rst is high; after reset they are combinational.
  - dccm_rden = dccm_wren = 0.
  - All address and data outputs = 0.
  - ld_rsp_valid = dma_rsp_valid = 0.
  - Starvation counters = 0; tag pipeline cleared.
- Read granted in cycle N: response valid in cycle N+1 (LOAD_TO_USE_PLUS1=0) or N+2 (=1).
- Back-to-back reads are sustained at 1 per cycle; responses return in grant order.
- Write granted in cycle N: memory updated at the edge ending cycle N. A read granted in N+1 returns the new data.
- Reset asserted mid-operation: in-flight response tags are dropped and no response strobe appears after reset.
- Counter saturates at STARVE_MAX. It never wraps.

## Test plan
- **Single load.** ld_req_valid with lo=hi=0x0010, memory preloaded with 0x12345678+ECC → ld_req_ready same cycle, dccm_rden=1, ld_rsp_valid one cycle later with rsp_data_lo equal to the preload. With LOAD_TO_USE_PLUS1=1, the response arrives two cycles later.
- **Priority.** Load, DMA and store all valid in one cycle, counters at 0 → load granted, counters for DMA and store = 1.
- **Starvation.** STARVE_MAX=4, load valid continuously, DMA read valid → DMA granted in the 5th cycle, load stalled that cycle, DMA counter back to 0, dma_rsp_valid one cycle later.
- **Dual promotion.** DMA and store both reach STARVE_MAX in the same cycle → DMA granted in that cycle, store granted in the next cycle despite load being valid.
- **Write then read.** Store to 0x0020 with data 0xA5 in cycle N, load of 0x0020 in N+1 → response data 0xA5.
- **Reset mid-flight.** Assert rst in the cycle after a load grant → ld_rsp_valid stays 0, all outputs return to their reset values, and the first grant after deassertion behaves normally.

Source files
------------

// File: rtl/eh2_lsu_dccm_arb_if.sv
// Request, command and response signals between the DCCM arbiter and its
// requesters (load pipe, DMA, store buffer) and the DCCM memory wrapper.
interface eh2_lsu_dccm_arb_if #(
  parameter int DCCM_BITS = 16,
  parameter int DATA_W    = 39
);
  // Load pipe
  logic                 ld_req_valid;
  logic                 ld_req_ready;
  logic [DCCM_BITS-1:0] ld_addr_lo;
  logic [DCCM_BITS-1:0] ld_addr_hi;
  // DMA slave port
  logic                 dma_req_valid;
  logic                 dma_req_ready;
  logic                 dma_req_write;
  logic [DCCM_BITS-1:0] dma_addr;
  logic [DATA_W-1:0]    dma_wdata;
  // Store-buffer drain
  logic                 stb_req_valid;
  logic                 stb_req_ready;
  logic [DCCM_BITS-1:0] stb_addr_lo;
  logic [DCCM_BITS-1:0] stb_addr_hi;
  logic [DATA_W-1:0]    stb_wdata_lo;
  logic [DATA_W-1:0]    stb_wdata_hi;
  // DCCM memory wrapper command and read data
  logic                 dccm_rden;
  logic                 dccm_wren;
  logic [DCCM_BITS-1:0] dccm_rd_addr_lo;
  logic [DCCM_BITS-1:0] dccm_rd_addr_hi;
  logic [DCCM_BITS-1:0] dccm_wr_addr_lo;
  logic [DCCM_BITS-1:0] dccm_wr_addr_hi;
  logic [DATA_W-1:0]    dccm_wr_data_lo;
  logic [DATA_W-1:0]    dccm_wr_data_hi;
  logic [DATA_W-1:0]    dccm_rd_data_lo;
  logic [DATA_W-1:0]    dccm_rd_data_hi;
  // Read responses
  logic                 ld_rsp_valid;
  logic                 dma_rsp_valid;
  logic [DATA_W-1:0]    rsp_data_lo;
  logic [DATA_W-1:0]    rsp_data_hi;

  // Arbiter side
  modport slave (
    input  ld_req_valid, ld_addr_lo, ld_addr_hi,
    output ld_req_ready,
    input  dma_req_valid, dma_req_write, dma_addr, dma_wdata,
    output dma_req_ready,
    input  stb_req_valid, stb_addr_lo, stb_addr_hi, stb_wdata_lo, stb_wdata_hi,
    output stb_req_ready,
    output dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
    output dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
    input  dccm_rd_data_lo, dccm_rd_data_hi,
    output ld_rsp_valid, dma_rsp_valid, rsp_data_lo, rsp_data_hi
  );

  // Requester / memory side
  modport master (
    output ld_req_valid, ld_addr_lo, ld_addr_hi,
    input  ld_req_ready,
    output dma_req_valid, dma_req_write, dma_addr, dma_wdata,
    input  dma_req_ready,
    output stb_req_valid, stb_addr_lo, stb_addr_hi, stb_wdata_lo, stb_wdata_hi,
    input  stb_req_ready,
    input  dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
    input  dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
    output dccm_rd_data_lo, dccm_rd_data_hi,
    input  ld_rsp_valid, dma_rsp_valid, rsp_data_lo, rsp_data_hi
  );
endinterface

// File: rtl/eh2_lsu_dccm_arb.sv
// DCCM arbiter: picks one of load / DMA / store-drain per cycle, drives the
// memory wrapper command, and steers read data back to the right requester.
module eh2_lsu_dccm_arb #(
  parameter int DCCM_BITS         = 16,
  parameter int DATA_W            = 39,
  parameter int STARVE_MAX        = 4,
  parameter int LOAD_TO_USE_PLUS1 = 0
) (
  input  logic                clk,
  input  logic                rst,
  eh2_lsu_dccm_arb_if.slave   bus,
  output logic [3:0]          dbg_dma_starve_cnt,
  output logic [3:0]          dbg_stb_starve_cnt
);

  // Handshake: a requester raises valid with a stable payload and keeps both
  // until it sees ready in the same cycle; ready is the combinational grant,
  // and a cycle with valid & ready is one transfer.

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       gnt_ld;
  logic       gnt_dma;
  logic       gnt_stb;
  logic       dma_prom;
  logic       stb_prom;
  logic       dma_rd;
  logic       dma_wr;

  logic [3:0] dma_cnt_d, dma_cnt_q;
  logic [3:0] stb_cnt_d, stb_cnt_q;

  logic [DCCM_BITS-1:0] rd_addr_lo_d, rd_addr_lo_q;
  logic [DCCM_BITS-1:0] rd_addr_hi_d, rd_addr_hi_q;
  logic [DCCM_BITS-1:0] wr_addr_lo_d, wr_addr_lo_q;
  logic [DCCM_BITS-1:0] wr_addr_hi_d, wr_addr_hi_q;
  logic [DATA_W-1:0]    wr_data_lo_d, wr_data_lo_q;
  logic [DATA_W-1:0]    wr_data_hi_d, wr_data_hi_q;

  // Response tag: {is_ld, is_dma}
  logic [1:0] tag0_d, tag0_q;
  logic [1:0] tag1_d, tag1_q;
  logic [1:0] rsp_tag;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  assign dma_prom = bus.dma_req_valid && (dma_cnt_q == STARVE_LIM);
  assign stb_prom = bus.stb_req_valid && (stb_cnt_q == STARVE_LIM);

  always_comb begin
    gnt_ld  = 1'b0;
    gnt_dma = 1'b0;
    gnt_stb = 1'b0;
    if (!rst) begin
      // Promoted requesters pre-empt the load; DMA breaks a promotion tie.
      if (dma_prom)               gnt_dma = 1'b1;
      else if (stb_prom)          gnt_stb = 1'b1;
      else if (bus.ld_req_valid)  gnt_ld  = 1'b1;
      else if (bus.dma_req_valid) gnt_dma = 1'b1;
      else if (bus.stb_req_valid) gnt_stb = 1'b1;
    end
  end

  assign dma_rd = gnt_dma && !bus.dma_req_write;
  assign dma_wr = gnt_dma &&  bus.dma_req_write;

  assign bus.ld_req_ready  = gnt_ld;
  assign bus.dma_req_ready = gnt_dma;
  assign bus.stb_req_ready = gnt_stb;

  // ---------------------------------------------------------------------------
  // Starvation counters: count consecutive lost cycles, saturate at the limit
  // ---------------------------------------------------------------------------
  always_comb begin
    dma_cnt_d = dma_cnt_q;
    if (!bus.dma_req_valid || gnt_dma) begin
      dma_cnt_d = 4'd0;
    end else if (dma_cnt_q < STARVE_LIM) begin
      dma_cnt_d = dma_cnt_q + 4'd1;
    end
  end

  always_comb begin
    stb_cnt_d = stb_cnt_q;
    if (!bus.stb_req_valid || gnt_stb) begin
      stb_cnt_d = 4'd0;
    end else if (stb_cnt_q < STARVE_LIM) begin
      stb_cnt_d = stb_cnt_q + 4'd1;
    end
  end

  assign dbg_dma_starve_cnt = dma_cnt_q;
  assign dbg_stb_starve_cnt = stb_cnt_q;

  // ---------------------------------------------------------------------------
  // Memory command: addresses/data follow the winner, otherwise hold
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr_lo_d = rd_addr_lo_q;
    rd_addr_hi_d = rd_addr_hi_q;
    if (gnt_ld) begin
      rd_addr_lo_d = bus.ld_addr_lo;
      rd_addr_hi_d = bus.ld_addr_hi;
    end else if (dma_rd) begin
      rd_addr_lo_d = bus.dma_addr;
      rd_addr_hi_d = bus.dma_addr;
    end
  end

  always_comb begin
    wr_addr_lo_d = wr_addr_lo_q;
    wr_addr_hi_d = wr_addr_hi_q;
    wr_data_lo_d = wr_data_lo_q;
    wr_data_hi_d = wr_data_hi_q;
    if (gnt_stb) begin
      wr_addr_lo_d = bus.stb_addr_lo;
      wr_addr_hi_d = bus.stb_addr_hi;
      wr_data_lo_d = bus.stb_wdata_lo;
      wr_data_hi_d = bus.stb_wdata_hi;
    end else if (dma_wr) begin
      wr_addr_lo_d = bus.dma_addr;
      wr_addr_hi_d = bus.dma_addr;
      wr_data_lo_d = bus.dma_wdata;
      wr_data_hi_d = bus.dma_wdata;
    end
  end

  assign bus.dccm_rden       = gnt_ld || dma_rd;
  assign bus.dccm_wren       = gnt_stb || dma_wr;
  assign bus.dccm_rd_addr_lo = rd_addr_lo_d;
  assign bus.dccm_rd_addr_hi = rd_addr_hi_d;
  assign bus.dccm_wr_addr_lo = wr_addr_lo_d;
  assign bus.dccm_wr_addr_hi = wr_addr_hi_d;
  assign bus.dccm_wr_data_lo = wr_data_lo_d;
  assign bus.dccm_wr_data_hi = wr_data_hi_d;

  // ---------------------------------------------------------------------------
  // Response tag pipeline; stage 1 only matters with the registered wrapper
  // ---------------------------------------------------------------------------
  always_comb begin
    tag0_d = {gnt_ld, dma_rd};
    tag1_d = tag0_q;
  end

  assign rsp_tag           = (LOAD_TO_USE_PLUS1 != 0) ? tag1_q : tag0_q;
  assign bus.ld_rsp_valid  = rsp_tag[1];
  assign bus.dma_rsp_valid = rsp_tag[0];
  assign bus.rsp_data_lo   = bus.dccm_rd_data_lo;
  assign bus.rsp_data_hi   = bus.dccm_rd_data_hi;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_cnt_q    <= 4'd0;
      stb_cnt_q    <= 4'd0;
      rd_addr_lo_q <= '0;
      rd_addr_hi_q <= '0;
      wr_addr_lo_q <= '0;
      wr_addr_hi_q <= '0;
      wr_data_lo_q <= '0;
      wr_data_hi_q <= '0;
      tag0_q       <= 2'b00;
      tag1_q       <= 2'b00;
    end else begin
      dma_cnt_q    <= dma_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      rd_addr_lo_q <= rd_addr_lo_d;
      rd_addr_hi_q <= rd_addr_hi_d;
      wr_addr_lo_q <= wr_addr_lo_d;
      wr_addr_hi_q <= wr_addr_hi_d;
      wr_data_lo_q <= wr_data_lo_d;
      wr_data_hi_q <= wr_data_hi_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
    end
  end

endmodule

// File: tb/tb_eh2_lsu_dccm_arb.sv
// Directed bench for eh2_lsu_dccm_arb: a zero-wait-state DCCM model behind the
// main instance and a one-extra-stage model behind a LOAD_TO_USE_PLUS1 copy.
module tb_eh2_lsu_dccm_arb;

  localparam int DB = 16;
  localparam int DW = 39;

  localparam logic [DW-1:0] PRE10 = {7'h2a, 32'h1234_5678};
  localparam logic [DW-1:0] PRE30 = {7'h11, 32'hcafe_0030};
  localparam logic [DW-1:0] SD_LO = {7'h01, 32'h0000_0401};
  localparam logic [DW-1:0] SD_HI = {7'h02, 32'h0000_0402};
  localparam logic [DW-1:0] A5    = 39'h00_0000_00a5;
  localparam logic [DW-1:0] DWR   = {7'h7f, 32'hdead_beef};

  logic clk;
  logic rst;
  logic [3:0] dma_cnt, stb_cnt, dma_cnt2, stb_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  eh2_lsu_dccm_arb_if #(.DCCM_BITS(DB), .DATA_W(DW)) bus ();
  eh2_lsu_dccm_arb_if #(.DCCM_BITS(DB), .DATA_W(DW)) bus2 ();

  eh2_lsu_dccm_arb #(.DCCM_BITS(DB), .DATA_W(DW), .STARVE_MAX(4), .LOAD_TO_USE_PLUS1(0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_dma_starve_cnt(dma_cnt), .dbg_stb_starve_cnt(stb_cnt)
  );

  eh2_lsu_dccm_arb #(.DCCM_BITS(DB), .DATA_W(DW), .STARVE_MAX(4), .LOAD_TO_USE_PLUS1(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .dbg_dma_starve_cnt(dma_cnt2), .dbg_stb_starve_cnt(stb_cnt2)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- memory model
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd1_lo, rd1_hi, rd2_lo, rd2_hi;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= PRE10;
      mem[8'h30] <= PRE30;
      rd1_lo <= '0;
      rd1_hi <= '0;
      rd2_lo <= '0;
      rd2_hi <= '0;
    end else begin
      if (bus.dccm_wren) begin
        mem[bus.dccm_wr_addr_lo[7:0]] <= bus.dccm_wr_data_lo;
        mem[bus.dccm_wr_addr_hi[7:0]] <= bus.dccm_wr_data_hi;
      end
      if (bus.dccm_rden) begin
        rd1_lo <= mem[bus.dccm_rd_addr_lo[7:0]];
        rd1_hi <= mem[bus.dccm_rd_addr_hi[7:0]];
      end
      rd2_lo <= rd1_lo;
      rd2_hi <= rd1_hi;
    end
  end

  assign bus.dccm_rd_data_lo  = rd1_lo;
  assign bus.dccm_rd_data_hi  = rd1_hi;
  assign bus2.dccm_rd_data_lo = rd2_lo;
  assign bus2.dccm_rd_data_hi = rd2_hi;

  assign bus2.ld_req_valid  = bus.ld_req_valid;
  assign bus2.ld_addr_lo    = bus.ld_addr_lo;
  assign bus2.ld_addr_hi    = bus.ld_addr_hi;
  assign bus2.dma_req_valid = bus.dma_req_valid;
  assign bus2.dma_req_write = bus.dma_req_write;
  assign bus2.dma_addr      = bus.dma_addr;
  assign bus2.dma_wdata     = bus.dma_wdata;
  assign bus2.stb_req_valid = bus.stb_req_valid;
  assign bus2.stb_addr_lo   = bus.stb_addr_lo;
  assign bus2.stb_addr_hi   = bus.stb_addr_hi;
  assign bus2.stb_wdata_lo  = bus.stb_wdata_lo;
  assign bus2.stb_wdata_hi  = bus.stb_wdata_hi;

  // ---------------------------------------------------------------- checker
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ld(input logic v, input logic [DB-1:0] lo, input logic [DB-1:0] hi);
    bus.ld_req_valid = v;
    bus.ld_addr_lo   = lo;
    bus.ld_addr_hi   = hi;
  endtask

  task automatic drive_dma(input logic v, input logic wr, input logic [DB-1:0] a, input logic [DW-1:0] d);
    bus.dma_req_valid = v;
    bus.dma_req_write = wr;
    bus.dma_addr      = a;
    bus.dma_wdata     = d;
  endtask

  task automatic drive_stb(input logic v, input logic [DB-1:0] alo, input logic [DB-1:0] ahi,
                           input logic [DW-1:0] dlo, input logic [DW-1:0] dhi);
    bus.stb_req_valid = v;
    bus.stb_addr_lo   = alo;
    bus.stb_addr_hi   = ahi;
    bus.stb_wdata_lo  = dlo;
    bus.stb_wdata_hi  = dhi;
  endtask

  function automatic logic [2:0] grants();
    return {bus.ld_req_ready, bus.dma_req_ready, bus.stb_req_ready};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    drive_ld(1'b1, 16'h0010, 16'h0010);
    drive_dma(1'b0, 1'b0, '0, '0);
    drive_stb(1'b0, '0, '0, '0, '0);

    // Reset state, with a load already requesting
    #2;
    check_eq("rst_ready", 64'(grants()), 64'(3'b000));
    check_eq("rst_rden", 64'(bus.dccm_rden), 64'd0);
    check_eq("rst_wren", 64'(bus.dccm_wren), 64'd0);
    check_eq("rst_rd_addr", 64'({bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}), 64'd0);
    check_eq("rst_wr_addr", 64'({bus.dccm_wr_addr_lo, bus.dccm_wr_addr_hi}), 64'd0);
    check_eq("rst_wr_data", 64'(bus.dccm_wr_data_lo | bus.dccm_wr_data_hi), 64'd0);
    check_eq("rst_rsp", 64'({bus.ld_rsp_valid, bus.dma_rsp_valid}), 64'd0);
    check_eq("rst_cnts", 64'({dma_cnt, stb_cnt}), 64'd0);
    tick();
    tick();
    bus.ld_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("idle_ready", 64'(grants()), 64'(3'b000));

    // Single load, lo=hi=0x10
    drive_ld(1'b1, 16'h0010, 16'h0010);
    #1;
    check_eq("ld_grant", 64'(grants()), 64'(3'b100));
    check_eq("ld_rden", 64'({bus.dccm_rden, bus.dccm_wren}), 64'(2'b10));
    check_eq("ld_rd_addr", 64'({bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}), 64'h0010_0010);
    tick();
    bus.ld_req_valid = 1'b0;
    #1;
    check_eq("ld_rsp_n1", 64'({bus.ld_rsp_valid, bus.dma_rsp_valid}), 64'(2'b10));
    check_eq("ld_rsp_data_lo", 64'(bus.rsp_data_lo), 64'(PRE10));
    check_eq("ld_rsp_data_hi", 64'(bus.rsp_data_hi), 64'(PRE10));
    check_eq("ld_idle_rden", 64'(bus.dccm_rden), 64'd0);
    check_eq("ld_addr_hold", 64'(bus.dccm_rd_addr_lo), 64'h0010);
    check_eq("plus1_rsp_n1", 64'(bus2.ld_rsp_valid), 64'd0);
    tick();
    check_eq("ld_rsp_n2", 64'(bus.ld_rsp_valid), 64'd0);
    check_eq("plus1_rsp_n2", 64'(bus2.ld_rsp_valid), 64'd1);
    check_eq("plus1_rsp_data", 64'(bus2.rsp_data_lo), 64'(PRE10));

    // Priority: all three valid with counters at zero
    drive_ld(1'b1, 16'h0010, 16'h0010);
    drive_dma(1'b1, 1'b0, 16'h0030, '0);
    drive_stb(1'b1, 16'h0040, 16'h0044, SD_LO, SD_HI);
    #1;
    check_eq("prio_grant", 64'(grants()), 64'(3'b100));
    tick();
    check_eq("prio_cnts", 64'({dma_cnt, stb_cnt}), 64'h11);
    bus.ld_req_valid  = 1'b0;
    bus.dma_req_valid = 1'b0;
    bus.stb_req_valid = 1'b0;
    tick();
    check_eq("prio_cnt_clear", 64'({dma_cnt, stb_cnt}), 64'h00);

    // Starvation: load held, DMA read of 0x30 waits four cycles
    drive_ld(1'b1, 16'h0010, 16'h0010);
    drive_dma(1'b1, 1'b0, 16'h0030, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("starve_wait%0d", i), 64'(grants()), 64'(3'b100));
      tick();
    end
    #1;
    check_eq("starve_cnt_max", 64'(dma_cnt), 64'd4);
    check_eq("starve_grant", 64'(grants()), 64'(3'b010));
    check_eq("starve_rd_addr", 64'({bus.dccm_rd_addr_lo, bus.dccm_rd_addr_hi}), 64'h0030_0030);
    check_eq("starve_rden", 64'({bus.dccm_rden, bus.dccm_wren}), 64'(2'b10));
    tick();
    bus.dma_req_valid = 1'b0;
    #1;
    check_eq("starve_cnt_clr", 64'(dma_cnt), 64'd0);
    check_eq("starve_rsp", 64'({bus.ld_rsp_valid, bus.dma_rsp_valid}), 64'(2'b01));
    check_eq("starve_rsp_data", 64'(bus.rsp_data_lo), 64'(PRE30));
    check_eq("starve_ld_back", 64'(grants()), 64'(3'b100));
    bus.ld_req_valid = 1'b0;
    tick();

    // Dual promotion: DMA first, store the cycle after, load still valid
    drive_ld(1'b1, 16'h0010, 16'h0010);
    drive_dma(1'b1, 1'b0, 16'h0030, '0);
    drive_stb(1'b1, 16'h0040, 16'h0044, SD_LO, SD_HI);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("dual_wait%0d", i), 64'(grants()), 64'(3'b100));
      tick();
    end
    #1;
    check_eq("dual_cnts", 64'({dma_cnt, stb_cnt}), 64'h44);
    check_eq("dual_dma_grant", 64'(grants()), 64'(3'b010));
    tick();
    bus.dma_req_valid = 1'b0;
    #1;
    check_eq("dual_cnts_after", 64'({dma_cnt, stb_cnt}), 64'h04);
    check_eq("dual_stb_grant", 64'(grants()), 64'(3'b001));
    check_eq("dual_cmd", 64'({bus.dccm_rden, bus.dccm_wren}), 64'(2'b01));
    check_eq("dual_wr_addr", 64'({bus.dccm_wr_addr_lo, bus.dccm_wr_addr_hi}), 64'h0040_0044);
    check_eq("dual_wr_lo", 64'(bus.dccm_wr_data_lo), 64'(SD_LO));
    check_eq("dual_wr_hi", 64'(bus.dccm_wr_data_hi), 64'(SD_HI));
    check_eq("dual_dma_rsp", 64'(bus.dma_rsp_valid), 64'd1);
    tick();
    bus.stb_req_valid = 1'b0;
    #1;
    check_eq("dual_stb_cnt_clr", 64'(stb_cnt), 64'd0);
    check_eq("dual_ld_back", 64'(grants()), 64'(3'b100));
    bus.ld_req_valid = 1'b0;
    tick();

    // Store 0xA5 to 0x20, then load it back the next cycle
    drive_stb(1'b1, 16'h0020, 16'h0020, A5, A5);
    #1;
    check_eq("wr_stb_grant", 64'(grants()), 64'(3'b001));
    tick();
    bus.stb_req_valid = 1'b0;
    drive_ld(1'b1, 16'h0020, 16'h0020);
    #1;
    check_eq("wr_ld_grant", 64'(grants()), 64'(3'b100));
    tick();
    bus.ld_req_valid = 1'b0;
    #1;
    check_eq("wr_ld_rsp", 64'(bus.ld_rsp_valid), 64'd1);
    check_eq("wr_ld_data", 64'(bus.rsp_data_lo), 64'(A5));

    // DMA write to 0x50, then DMA read of the same word
    drive_dma(1'b1, 1'b1, 16'h0050, DWR);
    #1;
    check_eq("dmaw_grant", 64'(grants()), 64'(3'b010));
    check_eq("dmaw_cmd", 64'({bus.dccm_rden, bus.dccm_wren}), 64'(2'b01));
    check_eq("dmaw_addr", 64'({bus.dccm_wr_addr_lo, bus.dccm_wr_addr_hi}), 64'h0050_0050);
    check_eq("dmaw_data", 64'(bus.dccm_wr_data_hi), 64'(DWR));
    tick();
    bus.dma_req_write = 1'b0;
    #1;
    check_eq("dmaw_no_rsp", 64'(bus.dma_rsp_valid), 64'd0);
    check_eq("dmar_cmd", 64'({bus.dccm_rden, bus.dccm_wren}), 64'(2'b10));
    tick();
    bus.dma_req_valid = 1'b0;
    #1;
    check_eq("dmar_rsp", 64'({bus.ld_rsp_valid, bus.dma_rsp_valid}), 64'(2'b01));
    check_eq("dmar_data", 64'(bus.rsp_data_hi), 64'(DWR));

    // Reset in the cycle after a load grant
    drive_ld(1'b1, 16'h0010, 16'h0010);
    #1;
    check_eq("rmf_grant", 64'(grants()), 64'(3'b100));
    tick();
    rst = 1'b1;
    #1;
    check_eq("rmf_rsp", 64'({bus.ld_rsp_valid, bus.dma_rsp_valid}), 64'd0);
    check_eq("rmf_ready", 64'(grants()), 64'(3'b000));
    check_eq("rmf_rden", 64'({bus.dccm_rden, bus.dccm_wren}), 64'd0);
    check_eq("rmf_addr", 64'({bus.dccm_rd_addr_lo, bus.dccm_wr_addr_lo}), 64'd0);
    check_eq("rmf_data", 64'(bus.dccm_wr_data_lo | bus.dccm_wr_data_hi), 64'd0);
    tick();
    check_eq("rmf_rsp_late", 64'({bus.ld_rsp_valid, bus2.ld_rsp_valid}), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rmf_post_grant", 64'(grants()), 64'(3'b100));
    check_eq("rmf_post_addr", 64'(bus.dccm_rd_addr_lo), 64'h0010);
    check_eq("rmf_plus1_idle", 64'(bus2.ld_rsp_valid), 64'd0);
    tick();
    bus.ld_req_valid = 1'b0;
    #1;
    check_eq("rmf_post_rsp", 64'(bus.ld_rsp_valid), 64'd1);
    check_eq("rmf_post_data", 64'(bus.rsp_data_lo), 64'(PRE10));
    tick();
    check_eq("rmf_post_plus1", 64'(bus2.ld_rsp_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
